// File: rtl/booth_arbiter.sv
// booth_arbiter: two-client round-robin arbiter and sequencer for the shared
// byte-serial radix-4 Booth multiplier.
//   clk, rst        : clock, synchronous active-high reset
//   req[1:0]        : per-client request levels
//   a0/b0, a1/b1    : client operands, sampled at grant
//   grant[1:0]      : one-hot owner of the multiplier, 0 when idle
//   done[1:0], err  : one-cycle completion pulse to owner, watchdog error flag
//   result[15:0]    : last good product (low 16 bits)
//   busy            : high from first LOAD cycle through DONE
//   m_in, m_start, m_get : operand byte, start pulse, result release to multiplier
//   m_ready, m_out  : multiplier result-valid level and low product
module booth_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        err,
  output logic [15:0] result,
  output logic        busy,
  output logic [7:0]  m_in,
  output logic        m_start,
  output logic        m_get,
  input  logic        m_ready,
  input  logic [15:0] m_out
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GET,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [1:0]      lc, lc_n;
  logic [WCW-1:0]  wcnt, wcnt_n;
  logic            errf, errf_n;
  logic            last, last_n;
  logic [15:0]     opa, opa_n;
  logic [15:0]     opb, opb_n;
  logic [1:0]      grant_n;
  logic [1:0]      done_n;
  logic            err_n;
  logic [15:0]     result_n;
  logic            busy_n;
  logic [7:0]      m_in_n;
  logic            m_start_n;
  logic            m_get_n;
  logic            win;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lc      <= '0;
      wcnt    <= '0;
      errf    <= 1'b0;
      last    <= 1'b1;
      opa     <= '0;
      opb     <= '0;
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
      m_in    <= '0;
      m_start <= 1'b0;
      m_get   <= 1'b0;
    end else begin
      state   <= state_n;
      lc      <= lc_n;
      wcnt    <= wcnt_n;
      errf    <= errf_n;
      last    <= last_n;
      opa     <= opa_n;
      opb     <= opb_n;
      grant   <= grant_n;
      done    <= done_n;
      err     <= err_n;
      result  <= result_n;
      busy    <= busy_n;
      m_in    <= m_in_n;
      m_start <= m_start_n;
      m_get   <= m_get_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle early
  // so the registered copies line up with the state they belong to.
  always_comb begin
    state_n   = state;
    lc_n      = lc;
    wcnt_n    = wcnt;
    errf_n    = errf;
    last_n    = last;
    opa_n     = opa;
    opb_n     = opb;
    grant_n   = grant;
    done_n    = '0;
    err_n     = 1'b0;
    result_n  = result;
    m_in_n    = '0;
    m_start_n = 1'b0;
    m_get_n   = 1'b0;

    // Both requesting: the client not served last wins; otherwise the sole requester.
    win   = (req == 2'b11) ? ~last : req[1];
    sel_a = win ? a1 : a0;
    sel_b = win ? b1 : b0;

    unique case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_n   = S_LOAD;
          lc_n      = 2'd0;
          last_n    = win;
          grant_n   = win ? 2'b10 : 2'b01;
          opa_n     = sel_a;
          opb_n     = sel_b;
          m_start_n = 1'b1;
          m_in_n    = sel_a[7:0];
        end
      end

      S_LOAD: begin
        // lc names the byte on m_in this cycle; prepare the following one.
        lc_n = lc + 2'd1;
        unique case (lc)
          2'd0: m_in_n = opa[15:8];
          2'd1: m_in_n = opb[7:0];
          2'd2: m_in_n = opb[15:8];
          default: begin
            state_n = S_WAIT;
            wcnt_n  = '0;
          end
        endcase
      end

      S_WAIT: begin
        // Abandon once TIMEOUT cycles have elapsed without ready, so that
        // done with err lands TIMEOUT+7 cycles after the request.
        if (m_ready) begin
          state_n = S_GET;
          errf_n  = 1'b0;
          m_get_n = 1'b1;
        end else if (wcnt == WCW'(TIMEOUT)) begin
          state_n = S_GET;
          errf_n  = 1'b1;
          m_get_n = 1'b1;
        end else begin
          wcnt_n = wcnt + WCW'(1);
        end
      end

      S_GET: begin
        if (!errf) begin
          result_n = m_out;
        end
        done_n  = grant;
        err_n   = errf;
        state_n = S_DONE;
      end

      S_DONE: begin
        grant_n = '0;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule
